// File: rtl/rr_grant_arbiter8_if.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter8_if
//   Request/grant bundle between a set of requesters and rr_grant_arbiter8.
//   Ports (all logic):
//     req          N   level-sensitive request lines, one per requester
//     done         1   owner releases its grant (single-cycle pulse)
//     grant        N   registered one-hot grant, or all zero
//     grant_valid  1   equals |grant
//     timeout      1   one-cycle pulse when a grant is force-released
//   Modports:
//     master  requester side (drives req/done, observes grant)
//     slave   arbiter side (observes req/done, drives grant)
// ---------------------------------------------------------------------------
interface rr_grant_arbiter8_if #(
   parameter int N = 8
);
   logic [N-1:0] req;
   logic         done;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic         timeout;

   modport master (
      output req, done,
      input  grant, grant_valid, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_valid, timeout
   );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter8
//   Round-robin arbiter for up to 8 requesters. The registered one-hot grant
//   feeds an 8-to-3 encoder downstream, so grant is only ever one-hot or zero.
//   A grant is held until the owner pulses done, drops its request, or has
//   held it for MAX_HOLD cycles (timeout). Every release is followed by
//   GAP_CYCLES cycles of all-zero grant before a new owner is picked.
//   Parameters:
//     N           number of requesters, power of 2, 2..8
//     MAX_HOLD    cycles a grant may stay asserted before forced release (>=2)
//     GAP_CYCLES  zero-grant cycles after each release (>=1)
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous reset, active-high, overrides every other input
//     bus   rr_grant_arbiter8_if.slave (req, done in; grant,
//           grant_valid, timeout out)
// ---------------------------------------------------------------------------
module rr_grant_arbiter8 #(
   parameter int N          = 8,
   parameter int MAX_HOLD   = 16,
   parameter int GAP_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   rr_grant_arbiter8_if.slave  bus
);

   localparam int PW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        state,       state_nxt;
   logic [N-1:0]  grant_r,     grant_nxt;
   logic          valid_r,     valid_nxt;
   logic          timeout_r,   timeout_nxt;
   logic [PW-1:0] grant_idx,   idx_nxt;
   logic [PW-1:0] ptr,         ptr_nxt;
   logic [HW-1:0] hold_cnt,    hold_nxt;
   logic [GW-1:0] gap_cnt,     gap_nxt;

   // Round-robin search: first requester at or after ptr, wrapping at N.
   // PW-bit addition wraps for free because N is a power of 2.
   logic          found;
   logic [PW-1:0] pick_idx;
   logic [PW-1:0] cand;

   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int i = 0; i < N; i++) begin
         cand = ptr + PW'(i);
         if (!found && bus.req[cand]) begin
            found    = 1'b1;
            pick_idx = cand;
         end
      end
   end

   logic take;
   logic release_req;
   logic expire;

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_nxt   = state;
      grant_nxt   = grant_r;
      valid_nxt   = valid_r;
      timeout_nxt = 1'b0;
      idx_nxt     = grant_idx;
      ptr_nxt     = ptr;
      hold_nxt    = hold_cnt;
      gap_nxt     = gap_cnt;
      take        = 1'b0;
      release_req = bus.done || !bus.req[grant_idx];
      expire      = (hold_cnt == HW'(MAX_HOLD - 1));

      case (state)
         IDLE: begin
            take = found;
         end

         BUSY: begin
            if (release_req || expire) begin
               state_nxt   = GAP;
               grant_nxt   = '0;
               valid_nxt   = 1'b0;
               ptr_nxt     = grant_idx + 1'b1;
               hold_nxt    = '0;
               gap_nxt     = GW'(GAP_CYCLES - 1);
               // An owner-initiated release on the last allowed cycle wins.
               timeout_nxt = !release_req;
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end

         GAP: begin
            // The edge closing the last gap cycle already performs the IDLE
            // search, so grant is zero for exactly GAP_CYCLES cycles.
            if (gap_cnt == '0) begin
               if (found) take = 1'b1;
               else       state_nxt = IDLE;
            end else begin
               gap_nxt = gap_cnt - 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
            grant_nxt = '0;
            valid_nxt = 1'b0;
         end
      endcase

      if (take) begin
         state_nxt = BUSY;
         grant_nxt = N'(1) << pick_idx;
         valid_nxt = 1'b1;
         idx_nxt   = pick_idx;
         hold_nxt  = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_r   <= '0;
         valid_r   <= 1'b0;
         timeout_r <= 1'b0;
         grant_idx <= '0;
         ptr       <= '0;
         hold_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         grant_r   <= grant_nxt;
         valid_r   <= valid_nxt;
         timeout_r <= timeout_nxt;
         grant_idx <= idx_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_nxt;
         gap_cnt   <= gap_nxt;
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_valid = valid_r;
   assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_arbiter8
//   Directed self-checking bench for rr_grant_arbiter8 (N=8, MAX_HOLD=16,
//   GAP_CYCLES=1). Each step drives req/done/rst, queues the expected grant
//   and timeout, and compares them one time unit after the next rising edge.
//   One-hot/zero grant, grant_valid==|grant and single-cycle timeout are
//   checked on every step.
// ---------------------------------------------------------------------------
module tb_rr_grant_arbiter8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rr_grant_arbiter8_if #(.N(8)) bus ();

   rr_grant_arbiter8 #(
      .N          (8),
      .MAX_HOLD   (16),
      .GAP_CYCLES (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0] grant;
      logic       timeout;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors  = 0;
   int   checks  = 0;
   logic prev_to = 1'b0;

   function automatic logic [2:0] enc(input logic [7:0] g);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock step: drive inputs, queue expectation, compare after the edge.
   task automatic cyc(input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic et, input string tag);
      exp_t e;
      rst      = r;
      bus.req  = rq;
      bus.done = d;
      e.grant   = eg;
      e.timeout = et;
      e.tag     = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".grant"},   32'(bus.grant),       32'(e.grant));
      chk({e.tag, ".valid"},   32'(bus.grant_valid), 32'(|e.grant));
      chk({e.tag, ".timeout"}, 32'(bus.timeout),     32'(e.timeout));
      chk({e.tag, ".onehot0"}, 32'($onehot0(bus.grant)), 32'd1);
      chk({e.tag, ".to_run"},  32'(prev_to && bus.timeout), 32'd0);
      prev_to = bus.timeout;
   endtask

   initial begin
      rst      = 1'b1;
      bus.req  = '0;
      bus.done = 1'b0;

      // Reset state
      cyc(1, 8'h00, 0, 8'h00, 0, "rst0");
      cyc(1, 8'h01, 0, 8'h00, 0, "rst1");

      // 1: single requester, release, one-cycle gap, re-grant
      cyc(0, 8'h01, 0, 8'h01, 0, "t1.grant");
      cyc(0, 8'h01, 1, 8'h00, 0, "t1.rel");
      cyc(0, 8'h01, 0, 8'h01, 0, "t1.regrant");
      cyc(0, 8'h01, 1, 8'h00, 0, "t1.rel2");
      cyc(0, 8'h00, 0, 8'h00, 0, "t1.idle");

      // 2: all requesting, rotation with wrap (ptr back to 0 via reset)
      cyc(1, 8'h00, 0, 8'h00, 0, "t2.rst");
      cyc(0, 8'hFF, 0, 8'h01, 0, "t2.g0");
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 8'hFF, 1, 8'h00, 0, $sformatf("t2.rel%0d", k));
         cyc(0, 8'hFF, 0, 8'h01 << (k % 8), 0, $sformatf("t2.g%0d", k));
      end
      cyc(0, 8'hFF, 1, 8'h00, 0, "t2.relend");
      cyc(0, 8'h00, 0, 8'h00, 0, "t2.idle");

      // 3: grant bit 2 (ptr becomes 3), then req=12 -> 10 then 02
      cyc(0, 8'h04, 0, 8'h04, 0, "t3.g2");
      cyc(0, 8'h04, 1, 8'h00, 0, "t3.rel2");
      cyc(0, 8'h12, 0, 8'h10, 0, "t3.g4");
      cyc(0, 8'h12, 1, 8'h00, 0, "t3.rel4");
      cyc(0, 8'h12, 0, 8'h02, 0, "t3.g1");
      cyc(0, 8'h12, 1, 8'h00, 0, "t3.rel1");
      cyc(0, 8'h00, 0, 8'h00, 0, "t3.idle");

      // 4: held request with no done -> 16-cycle grant then timeout
      cyc(0, 8'h04, 0, 8'h04, 0, "t4.hold0");
      for (int i = 1; i < 16; i++)
         cyc(0, 8'h04, 0, 8'h04, 0, $sformatf("t4.hold%0d", i));
      cyc(0, 8'h04, 0, 8'h00, 1, "t4.timeout");
      cyc(0, 8'h04, 0, 8'h04, 0, "t4.regrant");

      // 5: done on the timeout count is not a timeout; other req bits ignored
      for (int i = 1; i < 16; i++)
         cyc(0, 8'hFE, 0, 8'h04, 0, $sformatf("t5.hold%0d", i));
      cyc(0, 8'h04, 1, 8'h00, 0, "t5.done_at_max");
      cyc(0, 8'h04, 0, 8'h04, 0, "t5.regrant");
      cyc(0, 8'h04, 0, 8'h04, 0, "t5.held");
      cyc(0, 8'h00, 0, 8'h00, 0, "t5.reqdrop");
      cyc(0, 8'h00, 0, 8'h00, 0, "t5.idle");

      // 6: reset mid-BUSY clears grant and ptr
      cyc(0, 8'h20, 0, 8'h20, 0, "t6.g5");
      cyc(0, 8'h20, 0, 8'h20, 0, "t6.busy");
      cyc(1, 8'h20, 0, 8'h00, 0, "t6.rst");
      cyc(0, 8'h09, 0, 8'h01, 0, "t6.ptr0");
      cyc(0, 8'h09, 1, 8'h00, 0, "t6.rel0");
      cyc(0, 8'hC0, 0, 8'h40, 0, "t6.g6");
      chk("t6.enc", 32'(enc(bus.grant)), 32'd6);
      cyc(0, 8'hC0, 1, 8'h00, 0, "t6.rel6");
      cyc(0, 8'h00, 0, 8'h00, 0, "t6.idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
